seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner.sv | 99 +++++++++
 tb/tb_seven_seg_scanner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode 7-segment driver with per-frame snapshot, PWM and blanking.
// Define SEVSEG_LZ_SUPPRESS_EN to blank leading zeros at each snapshot.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV = 100_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [2:0]              brightness,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_done
);
  localparam int CW = $clog2(DIV);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0] c;
  logic [DW-1:0] d;
  logic idle, snap, lit;
  logic [4*NUM_DIGITS-1:0] s_data;
  logic [NUM_DIGITS-1:0] s_dp, s_blank, lz;
  logic [3:0] nib;
  logic [6:0] seg;
  // idle marks the first edge after reset or enable rising, which starts a frame
  assign snap = enable && (idle || (c == CW'(DIV-1) && d == DW'(NUM_DIGITS-1)));
  assign nib = s_data[4*d+:4];
  assign lit = enable && c >= CW'(BLANK_CYCLES) && c[2:0] <= brightness && !s_blank[d];
`ifdef SEVSEG_LZ_SUPPRESS_EN
  logic z;
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      z = z && data_in[4*i+:4] == 4'd0;
      lz[i] = z;
    end
  end
`else
  assign lz = '0;
`endif
  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      c <= '0;
      d <= '0;
      idle <= 1'b1;
      s_data <= '0;
      s_dp <= '0;
      s_blank <= '0;
      segments <= '1;
      dp <= 1'b1;
      anodes <= '1;
      frame_done <= 1'b0;
    end else begin
      idle <= !enable;
      frame_done <= snap;
      if (!enable || idle) begin
        c <= '0;
        d <= '0;
      end else if (c == CW'(DIV-1)) begin
        c <= '0;
        d <= d == DW'(NUM_DIGITS-1) ? '0 : d + 1'b1;
      end else
        c <= c + 1'b1;
      if (snap) begin
        s_data <= data_in;
        s_dp <= dp_in;
        s_blank <= blank_in | lz;
      end
      anodes <= lit ? ~(NUM_DIGITS'(1) << d) : '1;
      segments <= lit ? seg : '1;
      dp <= lit ? ~s_dp[d] : 1'b1;
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: vector table, corner sequences and a random run against a frame-arithmetic model.
module tb_seven_seg_scanner;
  localparam int N = 4, DIV = 16, BL = 2, FR = N*DIV, MAXC = 8192;
  localparam logic [6:0] DEC [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic clock = 0, reset = 1, enable = 0;
  logic [15:0] data_in = 0;
  logic [3:0] dp_in = 0, blank_in = 0;
  logic [2:0] brightness = 0;
  logic [6:0] segments;
  logic dp, frame_done;
  logic [3:0] anodes;
  seven_seg_scanner #(.NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BL)) dut (
    .clock(clock), .reset(reset), .enable(enable), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .brightness(brightness), .segments(segments), .dp(dp),
    .anodes(anodes), .frame_done(frame_done));
  always #5 clock = ~clock;
  int checks = 0, errors = 0, n = 0, s = 0;
  bit idle = 1;
  logic [15:0] hd [MAXC];
  logic [3:0] hp [MAXC], hb [MAXC];
  typedef struct packed {
    logic [15:0] d;
    logic [3:0] p, b;
    logic [2:0] br;
    logic [31:0] lit;
    logic [27:0] seg;
    logic [7:0] dpc;
  } vec_t;
  vec_t v [5];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask
  function automatic logic [3:0] lzm(logic [15:0] x);
    logic [3:0] m = '0;
`ifdef SEVSEG_LZ_SUPPRESS_EN
    int msd = 0;
    for (int i = 0; i < N; i++) if (x[4*i+:4] != 0) msd = i;
    for (int i = 0; i < N; i++) m[i] = i > msd;
`endif
    return m;
  endfunction
  task automatic step();
    logic [3:0] ea, bl;
    logic [6:0] es;
    logic ep, ef;
    int pos, c, dd, sn;
    n++;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles expected < %0d", n, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    hd[n] = data_in; hp[n] = dp_in; hb[n] = blank_in;
    @(posedge clock); #1;
    ea = '1; es = '1; ep = 1'b1; ef = 1'b0;
    if (!reset || !enable) idle = 1;
    else if (idle) begin
      idle = 0; s = n; ef = 1'b1;
    end else begin
      pos = (n - s - 1) % FR; c = pos % DIV; dd = pos / DIV;
      sn = s + FR * ((n - s - 1) / FR);
      ef = ((n - s) % FR) == 0;
      bl = hb[sn] | lzm(hd[sn]);
      if (c >= BL && c % 8 <= int'(brightness) && !bl[dd]) begin
        ea = ~(4'b1 << dd);
        es = DEC[hd[sn][4*dd+:4]];
        ep = ~hp[sn][dd];
      end
    end
    chk("anodes", 32'(anodes), 32'(ea));
    chk("segments", 32'(segments), 32'(es));
    chk("dp", 32'(dp), 32'(ep));
    chk("frame_done", 32'(frame_done), 32'(ef));
  endtask
  task automatic first_lit();
    int k = 0;
    while (anodes == 4'hF && k < 2*DIV) begin step(); k++; end
    chk("first_digit", 32'(anodes), 32'(4'b1110));
  endtask
  initial begin
    int cnt [4], dpc, z0, k;
    logic [6:0] sg [4];
    v[0] = '{16'h1A3F, 4'h0, 4'h0, 3'd7, {8'd14, 8'd14, 8'd14, 8'd14},
             {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, 8'd0};
    v[1] = '{16'h1A3F, 4'h0, 4'h0, 3'd0, {8'd1, 8'd1, 8'd1, 8'd1},
             {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, 8'd0};
    v[2] = '{16'h1A3F, 4'h0, 4'h0, 3'd3, {8'd6, 8'd6, 8'd6, 8'd6},
             {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, 8'd0};
    v[3] = '{16'h1A3F, 4'b0001, 4'b0100, 3'd7, {8'd14, 8'd0, 8'd14, 8'd14},
             {7'b1001111, 7'b1111111, 7'b0000110, 7'b0111000}, 8'd14};
`ifdef SEVSEG_LZ_SUPPRESS_EN
    v[4] = '{16'h0050, 4'h0, 4'h0, 3'd7, {8'd0, 8'd0, 8'd14, 8'd14},
             {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 8'd0};
`else
    v[4] = '{16'h0050, 4'h0, 4'h0, 3'd7, {8'd14, 8'd14, 8'd14, 8'd14},
             {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 8'd0};
`endif
    #2 reset = 0;
    #1;
    chk("reset_anodes", 32'(anodes), 32'(4'hF));
    chk("reset_segments", 32'(segments), 32'(7'h7F));
    chk("reset_dp", 32'(dp), 32'(1'b1));
    chk("reset_frame_done", 32'(frame_done), 32'(1'b0));
    step(); step();
    reset = 1;
    for (int r = 0; r < 5; r++) begin
      data_in = v[r].d; dp_in = v[r].p; blank_in = v[r].b; brightness = v[r].br;
      enable = 0; step(); step();
      enable = 1; step();
      for (int i = 0; i < N; i++) begin cnt[i] = 0; sg[i] = 7'h7F; end
      dpc = 0;
      repeat (FR) begin
        step();
        for (int i = 0; i < N; i++) if (!anodes[i]) begin
          cnt[i]++; sg[i] = segments; if (!dp) dpc++;
        end
      end
      for (int i = 0; i < N; i++) begin
        chk($sformatf("vec%0d_lit%0d", r, i), 32'(cnt[i]), 32'(v[r].lit[8*i+:8]));
        chk($sformatf("vec%0d_seg%0d", r, i), 32'(sg[i]), 32'(v[r].seg[7*i+:7]));
      end
      chk($sformatf("vec%0d_dp", r), 32'(dpc), 32'(v[r].dpc));
    end
    data_in = 16'h1A3F; dp_in = 0; blank_in = 0; brightness = 7;
    enable = 0; step(); enable = 1; step();
    repeat (20) step();
    data_in = 16'h0000;
    z0 = 0;
    repeat (FR - 20) begin step(); if (anodes != 4'hF && segments == DEC[0]) z0++; end
    chk("midframe_old_data", 32'(z0), 32'd0);
    chk("frame_done_at_frame_end", 32'(frame_done), 32'd1);
    z0 = 0;
    repeat (FR) begin step(); if (anodes != 4'hF && segments == DEC[0]) z0++; end
    chk("next_frame_new_data", 32'(z0), 32'd56);
    k = 0;
    do begin step(); k++; end while (!frame_done && k < 3*FR);
    chk("frame_period", 32'(k), 32'(FR));
    data_in = 16'h1A3F;
    repeat (2*DIV + 8) step();
    reset = 0; #1;
    chk("async_reset_anodes", 32'(anodes), 32'(4'hF));
    chk("async_reset_segments", 32'(segments), 32'(7'h7F));
    repeat (3) step();
    reset = 1; step();
    chk("reset_release_frame_done", 32'(frame_done), 32'd1);
    first_lit();
    repeat (DIV) step();
    enable = 0; step();
    chk("enable_fall_dark", 32'(anodes), 32'(4'hF));
    repeat (9) step();
    enable = 1; step();
    chk("enable_rise_frame_done", 32'(frame_done), 32'd1);
    first_lit();
    repeat (2500) begin
      if ($urandom_range(0, 7) == 0) data_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_in = 4'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
      if ($urandom_range(0, 199) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
